// File: rtl/atomik_pll_pkg.sv
// Shared definitions for the PLL reset/lock manager: state encoding and
// default timing constants for a 27 MHz reference clock.
package atomik_pll_pkg;

  // Bring-up sequencer states. Encodings 5..7 are unreachable and recover to PLL_RST.
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } pll_state_e;

  // Default timing, in 27 MHz clock cycles.
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 27000;  // 1 ms
  localparam int DEF_STABLE_CYCLES  = 2700;   // 100 us
  localparam int DEF_MAX_RETRIES    = 7;
  localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/atomik_sync_ff.sv
// Multi-flop synchroniser for asynchronous status inputs. Every stage resets
// to 0, so a reset synchroniser output always reads "not asserted".
module atomik_sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] chain_q [STAGES];

  // Shift the asynchronous input through STAGES flops; first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/atomik_pll_lock_mgr.sv
// PLL reset/lock manager. Holds the PLL in reset, waits for lock with a
// bounded number of retries, qualifies lock for a stable interval, then
// releases the system reset. All outputs come straight from flops that
// update on the same edge as the state register.
import atomik_pll_pkg::*;

module atomik_pll_lock_mgr #(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       lock_lost,
  output logic       pll_fail,
  output logic [3:0] retry_cnt
);

  // Parameter sanity: every count must be non-zero and fit the shared counter.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("atomik_pll_lock_mgr: SYNC_STAGES must be >= 2");
  end
  if (PLL_RST_CYCLES < 1 || 64'(PLL_RST_CYCLES) >= (64'd1 << CNT_W)) begin : g_chk_rst
    $error("atomik_pll_lock_mgr: PLL_RST_CYCLES out of range for CNT_W");
  end
  if (LOCK_TIMEOUT < 1 || 64'(LOCK_TIMEOUT) >= (64'd1 << CNT_W)) begin : g_chk_to
    $error("atomik_pll_lock_mgr: LOCK_TIMEOUT out of range for CNT_W");
  end
  if (STABLE_CYCLES < 1 || 64'(STABLE_CYCLES) >= (64'd1 << CNT_W)) begin : g_chk_stab
    $error("atomik_pll_lock_mgr: STABLE_CYCLES out of range for CNT_W");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_chk_retry
    $error("atomik_pll_lock_mgr: MAX_RETRIES must be 0..15");
  end

  // Terminal counts: a phase of N cycles ends when the counter shows N-1.
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  logic             lock_s;
  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             pll_ready_q, pll_ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic             pll_fail_q, pll_fail_d;

  atomik_sync_ff #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  // Next-state, shared counter and retry bookkeeping; counter clears on any state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    case (state_q)
      PLL_RST: begin
        // Lock is deliberately ignored while the PLL is held in reset.
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q >= RETRY_MAX) begin
            state_d = FAILED;
          end else begin
            state_d = PLL_RST;
            retry_d = retry_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE: begin
        // A lock drop restarts qualification without consuming a retry.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d     = PLL_RST;
          lock_lost_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FAILED: begin
        cnt_d   = '0;
        state_d = FAILED;
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values are decoded from the next state so they register alongside it.
  always_comb begin
    pll_reset_d = (state_d == PLL_RST);
    sys_rst_n_d = (state_d == RUN);
    pll_ready_d = (state_d == RUN);
    pll_fail_d  = (state_d == FAILED);
  end

  // State, counter and registered outputs; reset puts the PLL into reset and holds the system.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      pll_ready_q <= 1'b0;
      lock_lost_q <= 1'b0;
      pll_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      pll_ready_q <= pll_ready_d;
      lock_lost_q <= lock_lost_d;
      pll_fail_q  <= pll_fail_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign pll_ready = pll_ready_q;
  assign lock_lost = lock_lost_q;
  assign pll_fail  = pll_fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_atomik_pll_lock_mgr.sv
// Self-checking bench for atomik_pll_lock_mgr with shortened timing.
module tb_atomik_pll_lock_mgr;

  localparam int SYNC    = 2;
  localparam int RST_CYC = 4;
  localparam int TIMEOUT = 20;
  localparam int STAB    = 10;
  localparam int MAXR    = 2;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       lock_lost;
  logic       pll_fail;
  logic [3:0] retry_cnt;

  int n_checks;
  int n_errors;

  atomik_pll_lock_mgr #(
    .SYNC_STAGES    (SYNC),
    .PLL_RST_CYCLES (RST_CYC),
    .LOCK_TIMEOUT   (TIMEOUT),
    .STABLE_CYCLES  (STAB),
    .MAX_RETRIES    (MAXR),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .sys_rst_n (sys_rst_n),
    .pll_ready (pll_ready),
    .lock_lost (lock_lost),
    .pll_fail  (pll_fail),
    .retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (phase + time-in-phase) ----------------
  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAIL = 4;
  int m_phase;
  int m_enter;
  int m_retry;
  bit m_lost;
  int cyc;
  bit hist[$];

  task automatic model_reset();
    m_phase = M_RST;
    m_enter = cyc;
    m_retry = 0;
    m_lost  = 1'b0;
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
  endtask

  // One clock edge: each phase lasts a fixed number of edges unless lock changes it.
  task automatic model_step(input bit l);
    bit ls;
    int age;
    cyc++;
    ls = hist.pop_front();
    hist.push_back(l);
    age = cyc - m_enter;
    m_lost = 1'b0;
    case (m_phase)
      M_RST:  if (age == RST_CYC) begin m_phase = M_WAIT; m_enter = cyc; end
      M_WAIT: begin
        if (ls) begin m_phase = M_STAB; m_enter = cyc; end
        else if (age == TIMEOUT) begin
          if (m_retry == MAXR) m_phase = M_FAIL;
          else begin m_retry++; m_phase = M_RST; end
          m_enter = cyc;
        end
      end
      M_STAB: begin
        if (!ls) begin m_phase = M_WAIT; m_enter = cyc; end
        else if (age == STAB) begin m_phase = M_RUN; m_enter = cyc; m_retry = 0; end
      end
      M_RUN:  if (!ls) begin m_phase = M_RST; m_enter = cyc; m_lost = 1'b1; end
      default: ;
    endcase
  endtask

  function automatic logic [8:0] mk(int pr, int srn, int rdy, int ll, int pf, int rc);
    return {pr[0], srn[0], rdy[0], ll[0], pf[0], rc[3:0]};
  endfunction

  function automatic logic [8:0] model_vec();
    return mk(int'(m_phase == M_RST), int'(m_phase == M_RUN), int'(m_phase == M_RUN),
              int'(m_lost), int'(m_phase == M_FAIL), m_retry);
  endfunction

  function automatic logic [8:0] dut_vec();
    return {pll_reset, sys_rst_n, pll_ready, lock_lost, pll_fail, retry_cnt};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input bit l);
    pll_lock = l;
    @(posedge clk);
    #1;
    model_step(l);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int         reps;
    bit         lock;
    logic [8:0] exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    int run_left;
    bit lvl;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    pll_lock = 1'b0;

    // Nominal bring-up then loss in RUN, edge by edge after reset release.
    vt[0] = '{3,  1'b0, mk(1, 0, 0, 0, 0, 0)};  // e1..e3 PLL held in reset
    vt[1] = '{4,  1'b0, mk(0, 0, 0, 0, 0, 0)};  // e4..e7 waiting
    vt[2] = '{12, 1'b1, mk(0, 0, 0, 0, 0, 0)};  // e8..e19 sync + qualify
    vt[3] = '{1,  1'b1, mk(0, 1, 1, 0, 0, 0)};  // e20 RUN (8+2+10)
    vt[4] = '{5,  1'b1, mk(0, 1, 1, 0, 0, 0)};  // e21..e25 RUN
    vt[5] = '{2,  1'b0, mk(0, 1, 1, 0, 0, 0)};  // e26..e27 drop still in sync
    vt[6] = '{1,  1'b0, mk(1, 0, 0, 1, 0, 0)};  // e28 lock_lost pulse
    vt[7] = '{3,  1'b0, mk(1, 0, 0, 0, 0, 0)};  // e29..e31 PLL reset
    vt[8] = '{1,  1'b0, mk(0, 0, 0, 0, 0, 0)};  // e32 back to waiting

    @(posedge clk);
    #1;
    chk("reset_state", 32'(dut_vec()), 32'(mk(1, 0, 0, 0, 0, 0)));
    do_reset();
    for (int i = 0; i < 9; i++) begin
      for (int r = 0; r < vt[i].reps; r++) begin
        tick(vt[i].lock);
        chk($sformatf("vec%0d_%0d", i, r), 32'(dut_vec()), 32'(vt[i].exp));
      end
    end

    // Timeout retry: first attempt never locks, lock arrives during the second reset pulse.
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      tick(e >= 25);
      if (e == 4)  chk("retry_wait1", 32'(pll_reset), 32'd0);
      if (e == 24) chk("retry_timeout", 32'({pll_reset, retry_cnt}), 32'({1'b1, 4'd1}));
      if (e == 27) chk("retry_pr_last", 32'(pll_reset), 32'd1);
      if (e == 28) chk("retry_pr_end", 32'(pll_reset), 32'd0);
      if (e == 38) chk("retry_not_run", 32'({sys_rst_n, retry_cnt}), 32'({1'b0, 4'd1}));
      if (e == 39) chk("retry_run", 32'({sys_rst_n, pll_ready, retry_cnt}), 32'({2'b11, 4'd0}));
    end

    // Exhaustion: lock never comes; third timeout lands in FAILED.
    do_reset();
    for (int e = 1; e <= 90; e++) begin
      tick(1'b0);
      if (e == 24) chk("exh_rc1", 32'(retry_cnt), 32'd1);
      if (e == 48) chk("exh_rc2", 32'({pll_reset, retry_cnt}), 32'({1'b1, 4'd2}));
      if (e == 71) chk("exh_not_yet", 32'({pll_fail, retry_cnt}), 32'({1'b0, 4'd2}));
      if (e == 72) chk("exh_fail", 32'({pll_fail, pll_reset, retry_cnt}), 32'({2'b10, 4'd2}));
      if (e == 90) chk("exh_hold", 32'({pll_fail, pll_reset, retry_cnt}), 32'({2'b10, 4'd2}));
    end
    for (int e = 0; e < 10; e++) tick(1'b1);
    chk("exh_terminal", 32'({pll_fail, sys_rst_n, pll_reset}), 32'(3'b100));
    #3 rst_n = 1'b0;
    #1 chk("exh_clear", 32'(dut_vec()), 32'(mk(1, 0, 0, 0, 0, 0)));

    // Glitch in STABLE: 3-cycle and 1-cycle drops both restart qualification.
    for (int g = 0; g < 2; g++) begin
      int glen;
      glen = (g == 0) ? 3 : 1;
      do_reset();
      for (int e = 1; e <= 35; e++) begin
        tick((e >= 8) && !(e >= 16 && e < 16 + glen));
        if (e == 20)        chk($sformatf("glitch%0d_e20", glen), 32'(sys_rst_n), 32'd0);
        if (e == 27 + glen) chk($sformatf("glitch%0d_pre", glen), 32'({sys_rst_n, retry_cnt}), 32'd0);
        if (e == 28 + glen) chk($sformatf("glitch%0d_run", glen),
                                32'({sys_rst_n, pll_ready, retry_cnt}), 32'({2'b11, 4'd0}));
      end
    end

    // Asynchronous reset in the middle of a STABLE cycle.
    do_reset();
    for (int e = 1; e <= 14; e++) tick(e >= 8);
    chk("async_pre", 32'(pll_reset), 32'd0);
    #3 rst_n = 1'b0;
    #1 chk("async_rst", 32'(dut_vec()), 32'(mk(1, 0, 0, 0, 0, 0)));

    // Randomised lock waveforms against the reference model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      run_left = 0;
      lvl      = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (run_left == 0) begin
          lvl      = 1'($urandom_range(0, 1));
          run_left = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
        end
        tick(lvl);
        run_left--;
        chk($sformatf("rand_ep%0d_c%0d", ep, c), 32'(dut_vec()), 32'(model_vec()));
        if ($urandom_range(0, 299) == 0) do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
